endp_ctrl_regfile: RTL and testbench

//  CPU-side register file for the 4-endpoint USB slave controller.
//  - Owns the per-endpoint 5-bit control words driven to the endpoint mux.
//  - Reads back the per-endpoint status and transaction-type words the mux produces.
//  - Clears EP_READY when the mux pulses clrEPnRdy.
//  - Raises a maskable interrupt when an endpoint completes a transaction.

---
 rtl/endp_ctrl_regfile_if.sv | 13 +
 rtl/endp_ctrl_regfile.sv | 160 ++++++++++++++++
 tb/tb_endp_ctrl_regfile.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/endp_ctrl_regfile_if.sv
// CPU bus between the host processor and the USB endpoint control register file.
// One request at a time: stb is held until a single-cycle ack returns.
interface endp_ctrl_regfile_if;
    logic       stb;
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ack;

    modport master (output stb, we, addr, wdata, input rdata, ack);
    modport slave  (input stb, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/endp_ctrl_regfile.sv
// CPU register file for the 4-endpoint USB slave: control words, status readback, DONE/NAK interrupts.
// Optional feature: define ENDP_NAK_IRQ_EN to raise INT_STAT[7:4] on a rising NAK-sent status bit.
module endp_ctrl_regfile #(
    parameter int NUM_EP = 4,
    parameter int CTRL_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    endp_ctrl_regfile_if.slave bus,
    output logic [CTRL_W-1:0] endP0ControlReg,
    output logic [CTRL_W-1:0] endP1ControlReg,
    output logic [CTRL_W-1:0] endP2ControlReg,
    output logic [CTRL_W-1:0] endP3ControlReg,
    input  logic              clrEP0Rdy,
    input  logic              clrEP1Rdy,
    input  logic              clrEP2Rdy,
    input  logic              clrEP3Rdy,
    input  logic [7:0]        endP0StatusReg,
    input  logic [7:0]        endP1StatusReg,
    input  logic [7:0]        endP2StatusReg,
    input  logic [7:0]        endP3StatusReg,
    input  logic [1:0]        endP0TransTypeReg,
    input  logic [1:0]        endP1TransTypeReg,
    input  logic [1:0]        endP2TransTypeReg,
    input  logic [1:0]        endP3TransTypeReg,
    input  logic [1:0]        endP0NAKTransTypeReg,
    input  logic [1:0]        endP1NAKTransTypeReg,
    input  logic [1:0]        endP2NAKTransTypeReg,
    input  logic [1:0]        endP3NAKTransTypeReg,
    output logic              irq
);

    logic [NUM_EP-1:0][CTRL_W-1:0] ctrl_q;
    logic [NUM_EP-1:0][7:0]        status_in;
    logic [NUM_EP-1:0][1:0]        ttype_in;
    logic [NUM_EP-1:0][1:0]        nak_ttype_in;
    logic [NUM_EP-1:0]             clr_rdy;
    logic [NUM_EP-1:0]             done_set;
    logic [NUM_EP-1:0]             nak_set;

    logic       ack_reg;
    logic [7:0] rdata_reg;
    logic [7:0] int_stat_reg;
    logic [7:0] int_stat_next;
    logic [7:0] int_mask_reg;
    logic       irq_reg;
    logic [7:0] rd_mux;
    logic       accept;
    logic       wr_en;
    logic       rd_en;

    assign status_in    = {endP3StatusReg, endP2StatusReg, endP1StatusReg, endP0StatusReg};
    assign ttype_in     = {endP3TransTypeReg, endP2TransTypeReg, endP1TransTypeReg, endP0TransTypeReg};
    assign nak_ttype_in = {endP3NAKTransTypeReg, endP2NAKTransTypeReg,
                           endP1NAKTransTypeReg, endP0NAKTransTypeReg};
    assign clr_rdy      = {clrEP3Rdy, clrEP2Rdy, clrEP1Rdy, clrEP0Rdy};

    assign endP0ControlReg = ctrl_q[0];
    assign endP1ControlReg = ctrl_q[1];
    assign endP2ControlReg = ctrl_q[2];
    assign endP3ControlReg = ctrl_q[3];

    // The ack cycle itself never accepts, which spaces accesses at least two cycles apart.
    assign accept = bus.stb & ~ack_reg;
    assign wr_en  = accept & bus.we;
    assign rd_en  = accept & ~bus.we;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_EP; gi++) begin : g_ep
            logic [CTRL_W-1:0] ctrl_reg;
            logic              ctrl_wr;

            assign ctrl_wr = wr_en && !bus.addr[4] && (bus.addr[3:2] == 2'(gi))
                             && (bus.addr[1:0] == 2'b00);

            // A CPU write re-arms the endpoint even if the mux clears READY on the same edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ctrl_reg <= '0;
                end else if (ctrl_wr) begin
                    ctrl_reg <= bus.wdata[CTRL_W-1:0];
                end else if (clr_rdy[gi]) begin
                    ctrl_reg[1] <= 1'b0;
                end
            end

            assign ctrl_q[gi]   = ctrl_reg;
            assign done_set[gi] = clr_rdy[gi] & ctrl_reg[1];

`ifdef ENDP_NAK_IRQ_EN
            logic nak_prev_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    nak_prev_reg <= 1'b0;
                end else begin
                    nak_prev_reg <= status_in[gi][4];
                end
            end

            assign nak_set[gi] = status_in[gi][4] & ~nak_prev_reg;
`else
            assign nak_set[gi] = 1'b0;
`endif
        end
    endgenerate

    // New set events override a simultaneous write-one-to-clear of the same bit.
    always_comb begin
        int_stat_next = int_stat_reg;
        if (wr_en && (bus.addr == 5'h10)) begin
            int_stat_next = int_stat_next & ~bus.wdata;
        end
        int_stat_next = int_stat_next | {nak_set, done_set};
    end

    always_comb begin
        rd_mux = 8'h00;
        if (!bus.addr[4]) begin
            case (bus.addr[1:0])
                2'd0:    rd_mux = 8'(ctrl_q[bus.addr[3:2]]);
                2'd1:    rd_mux = status_in[bus.addr[3:2]];
                2'd2:    rd_mux = {4'b0000, nak_ttype_in[bus.addr[3:2]], ttype_in[bus.addr[3:2]]};
                default: rd_mux = 8'h00;
            endcase
        end else begin
            case (bus.addr[3:0])
                4'h0:    rd_mux = int_stat_reg;
                4'h1:    rd_mux = int_mask_reg;
                default: rd_mux = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_reg      <= 1'b0;
            rdata_reg    <= 8'h00;
            int_stat_reg <= 8'h00;
            int_mask_reg <= 8'h00;
            irq_reg      <= 1'b0;
        end else begin
            ack_reg      <= accept;
            int_stat_reg <= int_stat_next;
            irq_reg      <= |(int_stat_reg & int_mask_reg);
            if (rd_en) begin
                rdata_reg <= rd_mux;
            end
            if (wr_en && (bus.addr == 5'h11)) begin
                int_mask_reg <= bus.wdata;
            end
        end
    end

    assign bus.ack   = ack_reg;
    assign bus.rdata = rdata_reg;
    assign irq       = irq_reg;

endmodule

// File: tb/tb_endp_ctrl_regfile.sv
// Randomized and directed checks of endp_ctrl_regfile against a register-level reference model.
module tb_endp_ctrl_regfile;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    endp_ctrl_regfile_if bus_if();

    logic [3:0][4:0] ctrl_o;
    logic [3:0][7:0] stat_drv;
    logic [3:0][1:0] tt_drv;
    logic [3:0][1:0] ntt_drv;
    logic [3:0]      clr_drv;
    logic            irq;

    endp_ctrl_regfile dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .bus                  (bus_if),
        .endP0ControlReg      (ctrl_o[0]),
        .endP1ControlReg      (ctrl_o[1]),
        .endP2ControlReg      (ctrl_o[2]),
        .endP3ControlReg      (ctrl_o[3]),
        .clrEP0Rdy            (clr_drv[0]),
        .clrEP1Rdy            (clr_drv[1]),
        .clrEP2Rdy            (clr_drv[2]),
        .clrEP3Rdy            (clr_drv[3]),
        .endP0StatusReg       (stat_drv[0]),
        .endP1StatusReg       (stat_drv[1]),
        .endP2StatusReg       (stat_drv[2]),
        .endP3StatusReg       (stat_drv[3]),
        .endP0TransTypeReg    (tt_drv[0]),
        .endP1TransTypeReg    (tt_drv[1]),
        .endP2TransTypeReg    (tt_drv[2]),
        .endP3TransTypeReg    (tt_drv[3]),
        .endP0NAKTransTypeReg (ntt_drv[0]),
        .endP1NAKTransTypeReg (ntt_drv[1]),
        .endP2NAKTransTypeReg (ntt_drv[2]),
        .endP3NAKTransTypeReg (ntt_drv[3]),
        .irq                  (irq)
    );

    // Reference model state, in register-map terms.
    logic [4:0] ctrl_m [4];
    logic [7:0] int_stat_m;
    logic [7:0] int_mask_m;
    logic [7:0] rdata_m;
    logic       ack_m;
    logic       irq_m;
    logic       last_rd_m;
    logic [3:0] nak_prev_m;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int n = 0; n < 4; n++) ctrl_m[n] = 5'h00;
        int_stat_m = 8'h00;
        int_mask_m = 8'h00;
        rdata_m    = 8'h00;
        ack_m      = 1'b0;
        irq_m      = 1'b0;
        last_rd_m  = 1'b0;
        nak_prev_m = 4'h0;
    endtask

    function automatic logic [7:0] read_m(input logic [4:0] a);
        int n;
        n = int'(a[3:2]);
        if (a < 5'h10) begin
            case (a[1:0])
                2'd0:    return {3'b000, ctrl_m[n]};
                2'd1:    return stat_drv[n];
                2'd2:    return {4'b0000, ntt_drv[n], tt_drv[n]};
                default: return 8'h00;
            endcase
        end
        if (a == 5'h10) return int_stat_m;
        if (a == 5'h11) return int_mask_m;
        return 8'h00;
    endfunction

    // Advance one clock: apply the register-map rules to the model, then compare.
    task automatic step();
        logic       acc;
        logic       wr;
        logic [7:0] sets;
        logic       irq_n;
        acc  = bus_if.stb && !ack_m;
        wr   = acc && bus_if.we;
        sets = 8'h00;
        for (int n = 0; n < 4; n++) begin
            if (clr_drv[n] && ctrl_m[n][1]) sets[n] = 1'b1;
`ifdef ENDP_NAK_IRQ_EN
            if (stat_drv[n][4] && !nak_prev_m[n]) sets[4+n] = 1'b1;
`endif
            nak_prev_m[n] = stat_drv[n][4];
        end
        irq_n = |(int_stat_m & int_mask_m);
        if (acc && !bus_if.we) begin
            rdata_m   = read_m(bus_if.addr);
            last_rd_m = 1'b1;
        end else if (acc) begin
            last_rd_m = 1'b0;
        end
        for (int n = 0; n < 4; n++) begin
            if (wr && bus_if.addr == 5'(4 * n)) ctrl_m[n] = bus_if.wdata[4:0];
            else if (clr_drv[n]) ctrl_m[n][1] = 1'b0;
        end
        if (wr && bus_if.addr == 5'h10) int_stat_m = int_stat_m & ~bus_if.wdata;
        int_stat_m = int_stat_m | sets;
        if (wr && bus_if.addr == 5'h11) int_mask_m = bus_if.wdata;
        irq_m = irq_n;
        ack_m = acc;

        @(posedge clk);
        #1;
        check("ack", 32'(bus_if.ack), 32'(ack_m));
        check("irq", 32'(irq), 32'(irq_m));
        for (int n = 0; n < 4; n++)
            check($sformatf("ctrl%0d", n), 32'(ctrl_o[n]), 32'(ctrl_m[n]));
        if (ack_m) begin
            if (last_rd_m) begin
                check("rdata", 32'(bus_if.rdata), 32'(rdata_m));
                $display("txn RD addr=%02h rdata=%02h", bus_if.addr, bus_if.rdata);
            end else begin
                $display("txn WR addr=%02h wdata=%02h", bus_if.addr, bus_if.wdata);
            end
        end
    endtask

    task automatic bus_access(input logic we, input logic [4:0] a, input logic [7:0] d,
                              output logic [7:0] rd);
        bus_if.stb   = 1'b1;
        bus_if.we    = we;
        bus_if.addr  = a;
        bus_if.wdata = d;
        step();
        check("ack_latency", 32'(bus_if.ack), 32'd1);
        rd = bus_if.rdata;
        clr_drv    = 4'h0;
        bus_if.stb = 1'b0;
        step();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ack"}, 32'(bus_if.ack), 32'd0);
        check({tag, "_irq"}, 32'(irq), 32'd0);
        check({tag, "_rdata"}, 32'(bus_if.rdata), 32'd0);
        for (int n = 0; n < 4; n++)
            check($sformatf("%s_ctrl%0d", tag, n), 32'(ctrl_o[n]), 32'd0);
    endtask

    logic [7:0] rd;
    int         r;

    initial begin
        bus_if.stb   = 1'b0;
        bus_if.we    = 1'b0;
        bus_if.addr  = 5'h00;
        bus_if.wdata = 8'h00;
        clr_drv      = 4'h0;
        for (int n = 0; n < 4; n++) begin
            stat_drv[n] = 8'h00;
            tt_drv[n]   = 2'b00;
            ntt_drv[n]  = 2'b00;
        end
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        rst_n = 1'b1;

        // Write then read CTRL_1.
        bus_access(1'b1, 5'h04, 8'h13, rd);
        bus_access(1'b0, 5'h04, 8'h00, rd);
        check("t2_rdata", 32'(rd), 32'h13);
        check("t2_ctrl1", 32'(ctrl_o[1]), 32'h13);

        // Ready clear on endpoint 2 raises DONE_2 and, one cycle later, irq.
        bus_access(1'b1, 5'h11, 8'h04, rd);
        bus_access(1'b1, 5'h08, 8'h03, rd);
        clr_drv = 4'b0100;
        step();
        clr_drv = 4'h0;
        check("t3_ctrl2", 32'(ctrl_o[2]), 32'h01);
        check("t3_irq_early", 32'(irq), 32'd0);
        step();
        check("t3_irq", 32'(irq), 32'd1);
        bus_access(1'b0, 5'h10, 8'h00, rd);
        check("t3_int_stat", 32'(rd), 32'h04);
        bus_access(1'b1, 5'h10, 8'h04, rd);
        check("t3_irq_cleared", 32'(irq), 32'd0);

        // CPU re-arm coinciding with clrEP0Rdy keeps the CPU value and still flags DONE_0.
        bus_access(1'b1, 5'h00, 8'h03, rd);
        clr_drv = 4'b0001;
        bus_access(1'b1, 5'h00, 8'h03, rd);
        check("t4_ctrl0", 32'(ctrl_o[0]), 32'h03);
        bus_access(1'b0, 5'h10, 8'h00, rd);
        check("t4_int_stat", 32'(rd), 32'h01);

        // Status and transaction-type readback, plus an unmapped address.
        stat_drv[3] = 8'hA5;
        tt_drv[3]   = 2'b10;
        ntt_drv[3]  = 2'b01;
        bus_access(1'b0, 5'h0D, 8'h00, rd);
        check("t5_stat3", 32'(rd), 32'hA5);
        bus_access(1'b0, 5'h0E, 8'h00, rd);
        check("t5_ttype3", 32'(rd), 32'h06);
        bus_access(1'b0, 5'h1F, 8'h00, rd);
        check("t5_unmapped", 32'(rd), 32'h00);

        // NAK-sent rising edge on endpoint 1.
        bus_access(1'b1, 5'h10, 8'hFF, rd);
        bus_access(1'b1, 5'h11, 8'h20, rd);
        stat_drv[1] = 8'h00;
        step();
        stat_drv[1] = 8'h10;
        step();
        step();
        bus_access(1'b0, 5'h10, 8'h00, rd);
`ifdef ENDP_NAK_IRQ_EN
        check("t6_int_stat", 32'(rd), 32'h20);
        check("t6_irq", 32'(irq), 32'd1);
`else
        check("t6_int_stat", 32'(rd), 32'h00);
        check("t6_irq", 32'(irq), 32'd0);
`endif

        // Randomized traffic mixing bus accesses, ready clears and status changes.
        for (int i = 0; i < 500; i++) begin
            if (bus_if.stb && bus_if.ack) begin
                bus_if.stb = 1'b0;
            end else if (!bus_if.stb && $urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, 9);
                if (r < 6)       bus_if.addr = 5'($urandom_range(0, 15));
                else if (r < 8)  bus_if.addr = 5'h10;
                else if (r == 8) bus_if.addr = 5'h11;
                else             bus_if.addr = 5'($urandom_range(0, 31));
                bus_if.we    = 1'($urandom_range(0, 1));
                bus_if.wdata = 8'($urandom);
                bus_if.stb   = 1'b1;
            end
            for (int n = 0; n < 4; n++) clr_drv[n] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 3);
                stat_drv[r] = 8'($urandom);
                tt_drv[r]   = 2'($urandom);
                ntt_drv[r]  = 2'($urandom);
            end
            step();
        end
        bus_if.stb = 1'b0;
        clr_drv    = 4'h0;
        step();
        step();

        // Reset asserted in the middle of a read, with live flags and control state.
        bus_access(1'b1, 5'h00, 8'h1F, rd);
        bus_access(1'b1, 5'h11, 8'hFF, rd);
        clr_drv = 4'b0001;
        step();
        clr_drv = 4'h0;
        step();
        check("pre_reset_irq", 32'(irq), 32'd1);
        bus_if.stb  = 1'b1;
        bus_if.we   = 1'b0;
        bus_if.addr = 5'h00;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        bus_if.stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("midrst_hold");
        reset_model();
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            bus_access(1'b0, 5'(4 * n), 8'h00, rd);
            check($sformatf("t1_ctrl%0d_read", n), 32'(rd), 32'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
